// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix drive/return lines plus the key event outputs.
// The scanner takes the master side; the matrix/downstream latch takes the slave side.
interface keypad_scanner_if;
  logic [2:0] col_in;     // column returns, active-low, asynchronous to clk
  logic [3:0] row_out;    // row drive, active-low one-cold
  logic [3:0] key_code;   // last accepted key code (0 = no key yet)
  logic       key_valid;  // one-cycle pulse per accepted press
  logic       key_held;   // high from acceptance until release is debounced

  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 phone keypad scanner: rotates a one-cold row drive, synchronizes and
// debounces the column returns and reports each accepted press once.
module keypad_scanner #(
  parameter int CLK_DIV      = 1000,  // clk cycles per scan tick (>= 4)
  parameter int DEBOUNCE_CNT = 4      // identical tick samples to accept press/release (2..255)
) (
  input  logic clk,
  input  logic reset,
  keypad_scanner_if.master kp
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  logic [2:0]    col_meta_reg;
  logic [2:0]    col_sync_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic          tick;

  state_t        state_reg, state_next;
  logic [3:0]    row_reg, row_next;
  logic [2:0]    cand_reg, cand_next;
  logic [7:0]    dcnt_reg, dcnt_next;
  logic [3:0]    code_reg, code_next;
  logic          valid_reg, valid_next;
  logic          held_reg, held_next;

  logic [1:0]    row_idx;
  logic [3:0]    col_code [3];
  logic [3:0]    cand_code;
  logic          single_low;
  logic [3:0]    row_rot;
  logic [7:0]    dcnt_inc;

  // Phone layout: rows 0..2 give 1..9, row 3 gives '*'=B, '0'=A, '#'=C.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'hB;
        2'd1:    code = 4'hA;
        2'd2:    code = 4'hC;
        default: code = 4'h0;
      endcase
    end else begin
      code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  // Two-flop synchronizer on the asynchronous column returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_reg <= 3'b000;
      col_sync_reg <= 3'b000;
    end else begin
      col_meta_reg <= kp.col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  assign tick = (tick_cnt_reg == TW'(CLK_DIV - 1));

  // Free-running scan tick divider, independent of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  // Index of the currently driven row.
  always_comb begin
    row_idx = 2'd0;
    case (row_reg)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_col
      assign col_code[gi] = key_map(row_idx, 2'(gi));
    end
  endgenerate

  // Code of the single column latched as the debounce candidate.
  always_comb begin
    cand_code = 4'h0;
    case (cand_reg)
      3'b110:  cand_code = col_code[0];
      3'b101:  cand_code = col_code[1];
      3'b011:  cand_code = col_code[2];
      default: cand_code = 4'h0;
    endcase
  end

  // Multi-press or ghosting shows up as two or more low bits and is ignored.
  assign single_low = (col_sync_reg == 3'b110) || (col_sync_reg == 3'b101) ||
                      (col_sync_reg == 3'b011);
  assign row_rot    = {row_reg[2:0], row_reg[3]};
  assign dcnt_inc   = dcnt_reg + 8'd1;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SCAN;
      row_reg   <= 4'b1110;
      cand_reg  <= 3'b111;
      dcnt_reg  <= 8'd0;
      code_reg  <= 4'h0;
      valid_reg <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      cand_reg  <= cand_next;
      dcnt_reg  <= dcnt_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
      held_reg  <= held_next;
    end
  end

  // Scan/debounce/hold/release decisions, taken only on tick cycles.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    cand_next  = cand_reg;
    dcnt_next  = dcnt_reg;
    code_next  = code_reg;
    valid_next = 1'b0;
    held_next  = held_reg;
    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (single_low) begin
            cand_next  = col_sync_reg;
            dcnt_next  = 8'd1;
            state_next = DEBOUNCE;
          end else begin
            row_next = row_rot;
          end
        end
        DEBOUNCE: begin
          if (col_sync_reg == cand_reg) begin
            dcnt_next = dcnt_inc;
            if (dcnt_inc == 8'(DEBOUNCE_CNT)) begin
              state_next = HOLD;
              valid_next = 1'b1;
              code_next  = cand_code;
              held_next  = 1'b1;
            end
          end else begin
            state_next = SCAN;
            row_next   = row_rot;
          end
        end
        HOLD: begin
          if (col_sync_reg == 3'b111) begin
            state_next = RELEASE;
            dcnt_next  = 8'd1;
          end
        end
        RELEASE: begin
          if (col_sync_reg == 3'b111) begin
            dcnt_next = dcnt_inc;
            if (dcnt_inc == 8'(DEBOUNCE_CNT)) begin
              state_next = SCAN;
              held_next  = 1'b0;
              row_next   = row_rot;
            end
          end else begin
            state_next = HOLD;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  assign kp.row_out   = row_reg;
  assign kp.key_code  = code_reg;
  assign kp.key_valid = valid_reg;
  assign kp.key_held  = held_reg;
endmodule
